// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the program-counter generator.
// Optional build flag used by pc_gen: PC_GEN_ALIGN_CHECK_EN.
package pc_gen_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      SRC_SEQ,
      SRC_JUMP,
      SRC_FLUSH,
      SRC_PEND
   } src_t;

   localparam int unsigned DEF_XLEN      = 32;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_if.sv
// Control/request bundle between the core and the PC generator.
// The core drives the master side; pc_gen sits on the slave side.
interface pc_gen_if #(
   parameter int unsigned XLEN = pc_gen_pkg::DEF_XLEN
);

   logic            start_i;
   logic            stall_i;
   logic            jump_i;
   logic [XLEN-1:0] jump_pc_i;
   logic            flush_i;
   logic [XLEN-1:0] flush_pc_i;
   logic [XLEN-1:0] pc_o;
   logic            pc_valid_o;
   logic [XLEN-1:0] pc_next_seq_o;
   logic            misalign_o;

   modport master (
      output start_i, stall_i, jump_i, jump_pc_i, flush_i, flush_pc_i,
      input  pc_o, pc_valid_o, pc_next_seq_o, misalign_o
   );

   modport slave (
      input  start_i, stall_i, jump_i, jump_pc_i, flush_i, flush_pc_i,
      output pc_o, pc_valid_o, pc_next_seq_o, misalign_o
   );

endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer: holds a redirect that could not be
// applied yet. A flush overwrites a pending jump; a jump never displaces a flush.
module pc_redirect_buf
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            i_cap_flush,
   input  logic            i_cap_jump,
   input  logic [XLEN-1:0] i_flush_pc,
   input  logic [XLEN-1:0] i_jump_pc,
   input  logic            i_clear,
   output logic            o_valid,
   output logic [XLEN-1:0] o_target
);

   logic            r_valid;
   src_t            r_src;
   logic [XLEN-1:0] r_target;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_valid  <= 1'b0;
         r_src    <= SRC_SEQ;
         r_target <= '0;
      end else if (i_cap_flush) begin
         r_valid  <= 1'b1;
         r_src    <= SRC_FLUSH;
         r_target <= i_flush_pc;
      end else if (i_cap_jump && !(r_valid && (r_src == SRC_FLUSH))) begin
         r_valid  <= 1'b1;
         r_src    <= SRC_JUMP;
         r_target <= i_jump_pc;
      end else if (i_clear) begin
         r_valid  <= 1'b0;
      end
   end

   assign o_valid  = r_valid;
   assign o_target = r_target;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator with stall, start gating and pending redirects.
// Build flag PC_GEN_ALIGN_CHECK_EN drops misaligned redirect targets and flags them.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN       = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
   parameter int unsigned     INST_BYTES = 4
) (
   input logic     clk_i,
   input logic     rst_i,
   pc_gen_if.slave bus
);

   state_t          r_state;
   state_t          w_next_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_next_pc;
   logic [XLEN-1:0] w_pc_seq;
   src_t            w_src;
   logic            w_update;
   logic            w_flush_ok;
   logic            w_jump_ok;
   logic            w_cap_flush;
   logic            w_cap_jump;
   logic            w_pend_clear;
   logic            w_pend_valid;
   logic [XLEN-1:0] w_pend_target;

`ifdef PC_GEN_ALIGN_CHECK_EN
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

   logic r_misalign;
   logic w_flush_bad;
   logic w_jump_bad;

   assign w_flush_bad = bus.flush_i && ((bus.flush_pc_i & ALIGN_MASK) != '0);
   assign w_jump_bad  = bus.jump_i  && ((bus.jump_pc_i  & ALIGN_MASK) != '0);
   assign w_flush_ok  = bus.flush_i && !w_flush_bad;
   assign w_jump_ok   = bus.jump_i  && !w_jump_bad;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_flush_bad || w_jump_bad;
      end
   end

   assign bus.misalign_o = r_misalign;
`else
   assign w_flush_ok     = bus.flush_i;
   assign w_jump_ok      = bus.jump_i;
   assign bus.misalign_o = 1'b0;
`endif

   assign w_pc_seq = r_pc + XLEN'(INST_BYTES);
   assign w_update = bus.start_i && !bus.stall_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_pc    <= RESET_VEC;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
      end
   end

   // Leaving IDLE only takes a redirect; sequential advance needs RUN.
   // Any applied redirect retires the pending entry since it is now stale.
   always_comb begin
      w_next_state = bus.start_i ? RUN : IDLE;
      w_next_pc    = r_pc;
      w_src        = SRC_SEQ;
      w_cap_flush  = 1'b0;
      w_cap_jump   = 1'b0;
      if (w_update) begin
         if (w_flush_ok) begin
            w_src     = SRC_FLUSH;
            w_next_pc = bus.flush_pc_i;
         end else if (w_jump_ok) begin
            w_src     = SRC_JUMP;
            w_next_pc = bus.jump_pc_i;
         end else if (w_pend_valid) begin
            w_src     = SRC_PEND;
            w_next_pc = w_pend_target;
         end else if (r_state == RUN) begin
            w_next_pc = w_pc_seq;
         end
      end else begin
         w_cap_flush = w_flush_ok;
         w_cap_jump  = w_jump_ok;
      end
      w_pend_clear = (w_src != SRC_SEQ);
   end

   pc_redirect_buf #(
      .XLEN(XLEN)
   ) u_redirect_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_cap_flush(w_cap_flush),
      .i_cap_jump (w_cap_jump),
      .i_flush_pc (bus.flush_pc_i),
      .i_jump_pc  (bus.jump_pc_i),
      .i_clear    (w_pend_clear),
      .o_valid    (w_pend_valid),
      .o_target   (w_pend_target)
   );

   assign bus.pc_o          = r_pc;
   assign bus.pc_valid_o    = (r_state == RUN) && !bus.stall_i;
   assign bus.pc_next_seq_o = w_pc_seq;

endmodule
